// File: rtl/enc_pkg.sv
// Shared definitions for the 16-to-4 priority encoder slice: sizes, index
// types and the rule that merges the two 8-bit half encoders.
package enc_pkg;

  localparam int N_IN   = 16;
  localparam int IDX_W  = $clog2(N_IN);
  localparam int HALF_W = N_IN / 2;
  localparam int HIDX_W = IDX_W - 1;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [HIDX_W-1:0] hidx_t;
  typedef logic [HALF_W-1:0] half_t;

  // The upper half always outranks the lower half, so its index wins whenever
  // it has any request; the half selector becomes the index MSB.
  function automatic idx_t combine_idx(input logic  v_hi,
                                       input hidx_t idx_hi,
                                       input hidx_t idx_lo);
    idx_t r;
    if (v_hi) r = {1'b1, idx_hi};
    else      r = {1'b0, idx_lo};
    return r;
  endfunction

  // Two or more requests exist if either half has several, or both halves
  // have at least one each.
  function automatic logic combine_multi(input logic v_hi, input logic m_hi,
                                         input logic v_lo, input logic m_lo);
    return m_hi | m_lo | (v_hi & v_lo);
  endfunction

endpackage

// File: rtl/prio_enc_8_3.sv
// Combinational 8-to-3 priority encoder: index of the highest set bit, an
// any-request flag and a more-than-one-request flag.
module prio_enc_8_3
  import enc_pkg::*;
(
  input  half_t  req,
  output hidx_t  idx,
  output logic   vld,
  output logic   multi
);

  // Ascending scan: the last set bit seen is the highest, so it wins.
  always_comb begin
    idx = '0;
    for (int k = 0; k < HALF_W; k++) begin
      if (req[k]) idx = hidx_t'(k);
    end
  end

  assign vld = |req;

  // Clearing the lowest set bit leaves something only if a second bit was set.
  assign multi = |(req & (req - half_t'(1)));

endmodule

// File: rtl/encoder_16_4.sv
// Registered 16-to-4 priority encoder built from two 8-to-3 halves. The
// highest-numbered request wins; valid and multi qualify the index.
module encoder_16_4
  import enc_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] i,
  input  logic            enable,
  output idx_t            o,
  output logic            valid,
  output logic            multi
);

  // ---- stage p0: gate requests and encode combinationally ----
  logic [N_IN-1:0] req_p0;
  hidx_t           idx_hi_p0;
  hidx_t           idx_lo_p0;
  logic            v_hi_p0;
  logic            v_lo_p0;
  logic            m_hi_p0;
  logic            m_lo_p0;
  idx_t            idx_p0;
  logic            vld_p0;
  logic            multi_p0;

  // A disabled cycle looks exactly like an empty request vector, which
  // already encodes to o=0, valid=0, multi=0.
  assign req_p0 = enable ? i : '0;

  prio_enc_8_3 u_hi (
    .req   (req_p0[N_IN-1:HALF_W]),
    .idx   (idx_hi_p0),
    .vld   (v_hi_p0),
    .multi (m_hi_p0)
  );

  prio_enc_8_3 u_lo (
    .req   (req_p0[HALF_W-1:0]),
    .idx   (idx_lo_p0),
    .vld   (v_lo_p0),
    .multi (m_lo_p0)
  );

  assign idx_p0   = combine_idx(v_hi_p0, idx_hi_p0, idx_lo_p0);
  assign vld_p0   = v_hi_p0 | v_lo_p0;
  assign multi_p0 = combine_multi(v_hi_p0, m_hi_p0, v_lo_p0, m_lo_p0);

  // ---- stage p1: registered outputs ----
  idx_t idx_p1;
  logic vld_p1;
  logic multi_p1;

  // Register the encoded result; reset forces the idle value immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_p1   <= '0;
      vld_p1   <= 1'b0;
      multi_p1 <= 1'b0;
    end else begin
      idx_p1   <= idx_p0;
      vld_p1   <= vld_p0;
      multi_p1 <= multi_p0;
    end
  end

  assign o     = idx_p1;
  assign valid = vld_p1;
  assign multi = multi_p1;

endmodule

// File: tb/tb_encoder_16_4.sv
// Self-checking bench for encoder_16_4: directed scenarios plus a randomized
// back-to-back run against a bit-counting reference model.
`timescale 1ns/1ps
module tb_encoder_16_4;

  logic        clk;
  logic        rst_n;
  logic [15:0] i;
  logic        enable;
  logic [3:0]  o;
  logic        valid;
  logic        multi;

  int n_cmp;
  int n_fail;

  encoder_16_4 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i      (i),
    .enable (enable),
    .o      (o),
    .valid  (valid),
    .multi  (multi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: highest set index, any-set, and more-than-one-set by counting.
  function automatic void model(input logic [15:0] v, input logic en,
                                output logic [3:0] eo, output logic ev,
                                output logic em);
    int cnt;
    int top;
    cnt = 0;
    top = 0;
    if (en) begin
      for (int k = 0; k < 16; k++) begin
        if (v[k]) begin
          cnt = cnt + 1;
          top = k;
        end
      end
    end
    eo = (cnt > 0) ? 4'(top) : 4'd0;
    ev = (cnt > 0);
    em = (cnt > 1);
  endfunction

  // Apply inputs away from the edge, then step just past the next rising edge.
  task automatic drive(input logic [15:0] v, input logic en);
    @(negedge clk);
    i      = v;
    enable = en;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    // Power-on reset holds outputs idle.
    @(posedge clk);
    #1;
    n_cmp++;
    if ({o, valid, multi} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_initial: got o=%0d valid=%b multi=%b, want 0/0/0", o, valid, multi);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Load a real value, then pull reset mid-cycle.
    drive(16'h8000, 1'b1);
    n_cmp++;
    if ({o, valid, multi} !== {4'd15, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_preload: got o=%0d valid=%b multi=%b, want 15/1/0", o, valid, multi);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({o, valid, multi} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_async: got o=%0d valid=%b multi=%b, want 0/0/0", o, valid, multi);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({o, valid, multi} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_held: got o=%0d valid=%b multi=%b, want 0/0/0", o, valid, multi);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({o, valid, multi} !== {4'd15, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_release: got o=%0d valid=%b multi=%b, want 15/1/0", o, valid, multi);
    end
  endtask

  task automatic test_single_bits();
    for (int k = 0; k < 16; k++) begin
      drive(16'(1) << k, 1'b1);
      n_cmp++;
      if ({o, valid, multi} !== {4'(k), 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL single_bit_%0d: got o=%0d valid=%b multi=%b, want %0d/1/0", k, o, valid, multi, k);
      end
    end
  endtask

  task automatic test_priority();
    logic [15:0] vecs [3];
    logic [3:0]  want [3];
    vecs[0] = 16'h0011; want[0] = 4'd4;
    vecs[1] = 16'h0280; want[1] = 4'd9;
    vecs[2] = 16'h3200; want[2] = 4'd13;
    for (int n = 0; n < 3; n++) begin
      drive(vecs[n], 1'b1);
      n_cmp++;
      if ({o, valid, multi} !== {want[n], 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL priority_%h: got o=%0d valid=%b multi=%b, want %0d/1/1", vecs[n], o, valid, multi, want[n]);
      end
    end
  endtask

  task automatic test_half_boundary();
    drive(16'h0180, 1'b1);
    n_cmp++;
    if ({o, valid, multi} !== {4'd8, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL half_0180: got o=%0d valid=%b multi=%b, want 8/1/1", o, valid, multi);
    end
    drive(16'h0080, 1'b1);
    n_cmp++;
    if ({o, valid, multi} !== {4'd7, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL half_0080: got o=%0d valid=%b multi=%b, want 7/1/0", o, valid, multi);
    end
  endtask

  task automatic test_zero_enable();
    drive(16'h0000, 1'b1);
    n_cmp++;
    if ({o, valid, multi} !== 6'b0) begin
      n_fail++;
      $display("FAIL zero_in: got o=%0d valid=%b multi=%b, want 0/0/0", o, valid, multi);
    end
    drive(16'hFFFF, 1'b1);
    n_cmp++;
    if ({o, valid, multi} !== {4'd15, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL all_ones: got o=%0d valid=%b multi=%b, want 15/1/1", o, valid, multi);
    end
    drive(16'hFFFF, 1'b0);
    n_cmp++;
    if ({o, valid, multi} !== 6'b0) begin
      n_fail++;
      $display("FAIL disabled: got o=%0d valid=%b multi=%b, want 0/0/0", o, valid, multi);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v;
    logic        en;
    logic [3:0]  eo;
    logic        ev;
    logic        em;
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 4))
        0:       v = 16'(1) << $urandom_range(0, 15);
        1:       v = 16'h0000;
        2:       v = 16'($urandom) & 16'($urandom) & 16'($urandom);
        default: v = 16'($urandom);
      endcase
      en = ($urandom_range(0, 7) != 0);
      drive(v, en);
      model(v, en, eo, ev, em);
      n_cmp++;
      if ({o, valid, multi} !== {eo, ev, em}) begin
        n_fail++;
        $display("FAIL b2b_%0d i=%h en=%b: got o=%0d valid=%b multi=%b, want %0d/%b/%b",
                 n, v, en, o, valid, multi, eo, ev, em);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    i      = 16'h0000;
    enable = 1'b0;
    test_reset();
    test_single_bits();
    test_priority();
    test_half_boundary();
    test_zero_enable();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
